// File: rtl/alu_op_scheduler_if.sv
// Bundles the two requester ports, the response port and the ALU operand/result pins.
// No logic inside; all timing is set by the scheduler.
// Backpressure is carried by reqN_ready and rsp_ready.
interface alu_op_scheduler_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;
    logic        req0_cin;
    logic [1:0]  req0_sel;

    logic        req1_valid;
    logic        req1_ready;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;
    logic        req1_cin;
    logic [1:0]  req1_sel;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_err;

    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [1:0]  alu_sel;
    logic [15:0] alu_result;
    logic        alu_carry;

    // Scheduler side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin, req0_sel,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin, req1_sel,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err,
        input  rsp_ready,
        output alu_a, alu_b, alu_cin, alu_sel,
        input  alu_result, alu_carry
    );

    // Requester / consumer / ALU side
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin, req0_sel,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin, req1_sel,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err,
        output rsp_ready,
        input  alu_a, alu_b, alu_cin, alu_sel,
        output alu_result, alu_carry
    );
endinterface

// File: rtl/alu_op_scheduler.sv
// Round-robin front-end for the shared 8-bit ALU: two requesters in, one tagged response out.
// Latency: accept edge to rsp_valid is ALU_WAIT+1 cycles (1 cycle for an illegal op).
// Backpressure: one op in flight; requesters see ready only in IDLE, response held until rsp_ready.
module alu_op_scheduler #(
    parameter int unsigned ALU_WAIT = 1   // settle cycles, legal 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_scheduler_if.slave bus,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT);

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic [3:0]  wait_cnt;
    logic        id_q;

    logic        grant0;
    logic        grant1;
    logic        grant_any;
    logic        acc_id;
    logic [7:0]  acc_a;
    logic [7:0]  acc_b;
    logic        acc_cin;
    logic [1:0]  acc_sel;
    logic        acc_illegal;
    logic        accept;

    // Arbitration: a lone requester wins; on a tie the one not granted last time wins.
    always_comb begin
        grant0      = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1      = bus.req1_valid && (!bus.req0_valid || !last_grant);
        grant_any   = grant0 || grant1;
        acc_id      = grant1;
        acc_a       = grant1 ? bus.req1_a   : bus.req0_a;
        acc_b       = grant1 ? bus.req1_b   : bus.req0_b;
        acc_cin     = grant1 ? bus.req1_cin : bus.req0_cin;
        acc_sel     = grant1 ? bus.req1_sel : bus.req0_sel;
        acc_illegal = (acc_sel == 2'b11);
        accept      = (state == ST_IDLE) && grant_any;
    end

    // State register; reset drops any in-flight op at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: illegal ops skip the settle wait, RESP leaves only on handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    state_nxt = acc_illegal ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; readys are gated by rst_n so they drop while reset is held.
    always_comb begin
        bus.req0_ready = rst_n && (state == ST_IDLE) && grant0;
        bus.req1_ready = rst_n && (state == ST_IDLE) && grant1;
        bus.rsp_valid  = (state == ST_RESP);
        busy           = (state != ST_IDLE);
    end

    // Datapath: latch operands on accept, count down the settle time, capture the ALU outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant     <= 1'b1;
            id_q           <= 1'b0;
            wait_cnt       <= 4'd0;
            bus.alu_a      <= 8'd0;
            bus.alu_b      <= 8'd0;
            bus.alu_cin    <= 1'b0;
            bus.alu_sel    <= 2'd0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= 16'd0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_err    <= 1'b0;
        end else if (accept) begin
            last_grant <= acc_id;
            id_q       <= acc_id;
            if (acc_illegal) begin
                // ALU is left untouched; the response is synthesized here.
                bus.rsp_id     <= acc_id;
                bus.rsp_result <= 16'd0;
                bus.rsp_carry  <= 1'b0;
                bus.rsp_err    <= 1'b1;
            end else begin
                bus.alu_a   <= acc_a;
                bus.alu_b   <= acc_b;
                bus.alu_cin <= acc_cin;
                bus.alu_sel <= acc_sel;
                wait_cnt    <= WAIT_INIT;
            end
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) begin
                bus.rsp_id     <= id_q;
                bus.rsp_result <= bus.alu_result;
                bus.rsp_carry  <= bus.alu_carry;
                bus.rsp_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: directed scenarios plus random traffic against a transaction model.
// Model predicts readys, response timing and contents from the requests alone.
// A second instance with a 4-cycle settle time covers the longer wait.
module tb_alu_op_scheduler;

    localparam int MAIN_WAIT = 1;

    logic clk;
    logic rst_n;
    logic busy;
    logic busy4;

    alu_op_scheduler_if bus ();
    alu_op_scheduler_if bus4 ();

    alu_op_scheduler #(.ALU_WAIT(MAIN_WAIT)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    alu_op_scheduler #(.ALU_WAIT(4)) u_dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus4),
        .busy (busy4)
    );

    // Reference ALU: {carry, result}
    function automatic logic [16:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic cin, input logic [1:0] sel);
        logic [15:0] r;
        logic        c;
        case (sel)
            2'b00:   begin r = 16'(a) + 16'(b) + 16'(cin); c = r[8]; end
            2'b01:   begin r = 16'(a) - 16'(b);            c = (a < b); end
            2'b10:   begin r = 16'(a) * 16'(b);            c = 1'b0; end
            default: begin r = 16'd0;                      c = 1'b0; end
        endcase
        return {c, r};
    endfunction

    assign {bus.alu_carry, bus.alu_result}   = alu_fn(bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_sel);
    assign {bus4.alu_carry, bus4.alu_result} = alu_fn(bus4.alu_a, bus4.alu_b, bus4.alu_cin, bus4.alu_sel);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model of the main instance ----------------
    bit          m_busy;
    int          m_cd;        // cycles left before the response shows
    bit          m_last;
    logic        m_id;
    logic [15:0] m_res;
    logic        m_carry;
    logic        m_err;
    logic [7:0]  m_a, m_b;
    logic        m_cin;
    logic [1:0]  m_sel;
    int          n_acc;
    int          n_rsp;
    logic        e0, e1, ev;
    logic [7:0]  t_a, t_b;
    logic        t_cin;
    logic [1:0]  t_sel;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_cd = 0; m_last = 1;
            m_a = 0; m_b = 0; m_cin = 0; m_sel = 0;
            n_acc = 0; n_rsp = 0;
            chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
            chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
            chk("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
            chk("rst_busy",       32'(busy),           32'd0);
            chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
            chk("rst_alu_a",      32'(bus.alu_a),      32'd0);
        end else begin
            e0 = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
            e1 = !m_busy && bus.req1_valid && (!bus.req0_valid || !m_last);
            ev = m_busy && (m_cd == 0);
            chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
            chk("rsp_valid",  32'(bus.rsp_valid),  32'(ev));
            chk("busy",       32'(busy),           32'(m_busy));
            chk("alu_a",      32'(bus.alu_a),      32'(m_a));
            chk("alu_b",      32'(bus.alu_b),      32'(m_b));
            chk("alu_cin",    32'(bus.alu_cin),    32'(m_cin));
            chk("alu_sel",    32'(bus.alu_sel),    32'(m_sel));
            if (ev) begin
                chk("rsp_id",     32'(bus.rsp_id),     32'(m_id));
                chk("rsp_result", 32'(bus.rsp_result), 32'(m_res));
                chk("rsp_carry",  32'(bus.rsp_carry),  32'(m_carry));
                chk("rsp_err",    32'(bus.rsp_err),    32'(m_err));
            end
            if (e0 || e1) begin
                t_a   = e1 ? bus.req1_a   : bus.req0_a;
                t_b   = e1 ? bus.req1_b   : bus.req0_b;
                t_cin = e1 ? bus.req1_cin : bus.req0_cin;
                t_sel = e1 ? bus.req1_sel : bus.req0_sel;
                m_last = e1;
                m_id   = e1;
                m_busy = 1;
                n_acc++;
                if (t_sel == 2'b11) begin
                    m_cd = 0; m_res = 16'd0; m_carry = 1'b0; m_err = 1'b1;
                end else begin
                    m_a = t_a; m_b = t_b; m_cin = t_cin; m_sel = t_sel;
                    {m_carry, m_res} = alu_fn(t_a, t_b, t_cin, t_sel);
                    m_err = 1'b0;
                    m_cd  = MAIN_WAIT;
                end
            end else if (m_busy && m_cd > 0) begin
                m_cd--;
            end else if (m_busy && bus.rsp_ready) begin
                m_busy = 0;
                n_rsp++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [1:0] sel);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; bus.req0_sel = sel;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; bus.req1_sel = sel;
        end
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        bus.rsp_ready  = 1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        chk({name, "_drain_timeout"}, 32'(done), 32'd1);
    endtask

    int         order [4];
    int         ng;
    int         gnt;
    logic [7:0] op_a [2];
    logic [7:0] op_b [2];
    logic       op_cin [2];
    logic [1:0] op_sel [2];
    logic [7:0] last_a;
    logic [1:0] last_sel;
    bit         seen;

    initial begin
        rst_n = 1'b1;
        set_req(0, 0, 8'd0, 8'd0, 0, 2'd0);
        set_req(1, 0, 8'd0, 8'd0, 0, 2'd0);
        bus.rsp_ready = 0;
        bus4.req0_valid = 0; bus4.req0_a = 0; bus4.req0_b = 0; bus4.req0_cin = 0; bus4.req0_sel = 0;
        bus4.req1_valid = 0; bus4.req1_a = 0; bus4.req1_b = 0; bus4.req1_cin = 0; bus4.req1_sel = 0;
        bus4.rsp_ready = 1;
        #1 rst_n = 1'b0;
        // readys must stay low under reset even with a request pending
        bus.req0_valid = 1;
        repeat (3) @(negedge clk);
        chk("rst_ready_forced", 32'(bus.req0_ready), 32'd0);
        bus.req0_valid = 0;
        #2 rst_n = 1'b1;

        // ---- single add ----
        tick();
        set_req(0, 1, 8'hF0, 8'h20, 1, 2'b00);
        bus.rsp_ready = 1;
        @(negedge clk); chk("add_accept", 32'(bus.req0_ready), 32'd1);
        tick(); bus.req0_valid = 0;
        @(negedge clk); chk("add_c1_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("add_c2_valid",  32'(bus.rsp_valid),  32'd1);
        chk("add_c2_id",     32'(bus.rsp_id),     32'd0);
        chk("add_c2_result", 32'(bus.rsp_result), 32'h0111);
        chk("add_c2_carry",  32'(bus.rsp_carry),  32'd1);
        tick();
        @(negedge clk); chk("add_c3_busy", 32'(busy), 32'd0);

        // ---- multiply with a 5-cycle stall ----
        tick();
        set_req(1, 1, 8'hFF, 8'hFF, 0, 2'b10);
        bus.rsp_ready = 0;
        @(negedge clk); chk("mul_accept", 32'(bus.req1_ready), 32'd1);
        tick();
        bus.req1_valid = 0;
        bus.req0_valid = 1;            // competing request must be ignored while busy
        @(negedge clk);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mul_stall_valid",  32'(bus.rsp_valid),  32'd1);
            chk("mul_stall_result", 32'(bus.rsp_result), 32'hFE01);
            chk("mul_stall_id",     32'(bus.rsp_id),     32'd1);
            chk("mul_stall_rdy0",   32'(bus.req0_ready), 32'd0);
            chk("mul_stall_rdy1",   32'(bus.req1_ready), 32'd0);
            tick();
        end
        bus.rsp_ready  = 1;
        bus.req0_valid = 0;
        @(negedge clk); chk("mul_hs_valid", 32'(bus.rsp_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("mul_after_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mul_after_busy",  32'(busy),          32'd0);

        // ---- round-robin, both requesters always valid ----
        tick();
        for (int n = 0; n < 2; n++) begin
            op_a[n] = 8'($urandom); op_b[n] = 8'($urandom);
            op_cin[n] = 1'($urandom); op_sel[n] = 2'($urandom_range(0, 2));
            set_req(n, 1, op_a[n], op_b[n], op_cin[n], op_sel[n]);
        end
        ng = 0;
        for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
            @(negedge clk);
            gnt = -1;
            if (bus.req0_ready) gnt = 0;
            else if (bus.req1_ready) gnt = 1;
            if (gnt >= 0) begin
                order[ng] = gnt;
                ng++;
                last_a   = op_a[gnt];
                last_sel = op_sel[gnt];
            end
            tick();
            if (ng == 4) begin
                bus.req0_valid = 0;
                bus.req1_valid = 0;
            end else if (gnt >= 0) begin
                op_a[gnt] = 8'($urandom); op_b[gnt] = 8'($urandom);
                op_cin[gnt] = 1'($urandom); op_sel[gnt] = 2'($urandom_range(0, 2));
                set_req(gnt, 1, op_a[gnt], op_b[gnt], op_cin[gnt], op_sel[gnt]);
            end
        end
        chk("rr_count", 32'(ng), 32'd4);
        chk("rr_g0", 32'(order[0]), 32'd0);
        chk("rr_g1", 32'(order[1]), 32'd1);
        chk("rr_g2", 32'(order[2]), 32'd0);
        chk("rr_g3", 32'(order[3]), 32'd1);
        drain("rr");

        // ---- illegal op ----
        tick();
        set_req(0, 1, 8'h12, 8'h34, 1, 2'b11);
        @(negedge clk); chk("ill_accept", 32'(bus.req0_ready), 32'd1);
        tick(); bus.req0_valid = 0;
        @(negedge clk);
        chk("ill_valid",   32'(bus.rsp_valid),  32'd1);
        chk("ill_err",     32'(bus.rsp_err),    32'd1);
        chk("ill_result",  32'(bus.rsp_result), 32'd0);
        chk("ill_carry",   32'(bus.rsp_carry),  32'd0);
        chk("ill_alu_sel", 32'(bus.alu_sel),    32'(last_sel));
        chk("ill_alu_a",   32'(bus.alu_a),      32'(last_a));
        tick();
        @(negedge clk); chk("ill_busy", 32'(busy), 32'd0);

        // ---- reset during the settle wait ----
        tick();
        set_req(0, 1, 8'h05, 8'h09, 0, 2'b01);
        @(negedge clk); chk("rst_op_accept", 32'(bus.req0_ready), 32'd1);
        tick(); bus.req0_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy",   32'(busy),           32'd0);
        chk("midrst_valid",  32'(bus.rsp_valid),  32'd0);
        chk("midrst_alu_a",  32'(bus.alu_a),      32'd0);
        chk("midrst_alu_b",  32'(bus.alu_b),      32'd0);
        chk("midrst_alu_sel",32'(bus.alu_sel),    32'd0);
        chk("midrst_result", 32'(bus.rsp_result), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        chk("midrst_no_rsp", 32'(seen), 32'd0);
        tick();
        set_req(0, 1, 8'h01, 8'h02, 0, 2'b00);
        @(negedge clk); chk("post_rst_accept", 32'(bus.req0_ready), 32'd1);
        tick(); bus.req0_valid = 0;
        tick();
        @(negedge clk);
        chk("post_rst_valid",  32'(bus.rsp_valid),  32'd1);
        chk("post_rst_result", 32'(bus.rsp_result), 32'h0003);
        tick();

        // ---- 4-cycle settle instance ----
        bus4.req0_valid = 1; bus4.req0_a = 8'h09; bus4.req0_b = 8'h05; bus4.req0_sel = 2'b01;
        @(negedge clk); chk("w4_accept", 32'(bus4.req0_ready), 32'd1);
        tick(); bus4.req0_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k < 5) begin
                chk("w4_early_valid", 32'(bus4.rsp_valid), 32'd0);
            end else begin
                chk("w4_valid",  32'(bus4.rsp_valid),  32'd1);
                chk("w4_result", 32'(bus4.rsp_result), 32'h0004);
            end
        end

        // ---- random traffic ----
        for (int i = 0; i < 400; i++) begin
            tick();
            for (int n = 0; n < 2; n++) begin
                set_req(n, ($urandom_range(0, 9) < 6), 8'($urandom), 8'($urandom), 1'($urandom),
                        ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2)));
            end
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
        end
        tick();
        drain("rand");
        chk("rand_acc_vs_rsp", 32'(n_rsp), 32'(n_acc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_op_scheduler.md
# alu_op_scheduler

Sequencing front-end for the shared 8-bit ALU (add/sub/mul, 16-bit result plus carry). It accepts operation requests from two independent requesters over valid/ready handshakes and arbitrates round-robin. It drives the ALU operand/select inputs from registers, waits a configurable settle time, then captures result and carry. Each result returns on a single response port tagged with the originating requester.

## Interface
- ALU_WAIT, 1, cycles the ALU inputs are held before result capture (legal range 1-15)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  8 each  operands
- req0_cin  in  1  carry-in (add only)
- req0_sel  in  2  00 add, 01 sub, 10 mul, 11 illegal
- req1_valid, req1_ready, req1_a, req1_b, req1_cin, req1_sel: same as requester 0
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester index of response
- rsp_result  out  16  captured ALU result
- rsp_carry  out  1  captured ALU carry
- rsp_err  out  1  op was illegal (sel=11)
- alu_a, alu_b  out  8 each  registered ALU operands
- alu_cin  out  1  registered ALU carry-in
- alu_sel  out  2  registered ALU select
- alu_result  in  16  ALU result
- alu_carry  in  1  ALU carry
- busy  out  1  state != IDLE

## Operation
- Clock is clk. Reset is rst_n: asynchronous, active-low.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant logic: only one valid requester → grant it. Both valid → grant the requester not equal to last_grant.
  - reqN_ready = (state==IDLE) && granted N. This is combinational from the valids.
  - On handshake:
    - Latch a, b, cin, sel, and id into alu_* and an id register.
    - last_grant <= N.
    - Legal sel → WAIT, wait counter loaded with ALU_WAIT.
    - sel=11 → RESP directly with rsp_result=0, rsp_carry=0, rsp_err=1. alu_* are not updated.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle it reads 1: capture alu_result → rsp_result, alu_carry → rsp_carry, rsp_err=0, rsp_id=id, then → RESP.
- RESP:
  - rsp_valid=1. Outputs stay stable until rsp_ready.
  - On rsp_valid && rsp_ready → IDLE. No new request is accepted in that same cycle.
- alu_* hold their last value outside WAIT.
- Arithmetic is performed entirely by the ALU. The scheduler never modifies the result width or value.
- Reset values:
  - state=IDLE, last_grant=1 (so req0 wins the first tie).
  - All outputs 0: rsp_*, alu_*, busy, both readys.
  - Readys are forced 0 while rst_n is low.
- Reset asserted mid-operation: the in-flight op is discarded, no response is issued, and the FSM returns to IDLE immediately (asynchronously).

## Timing
- Accept on edge E (end of cycle T):
  - alu_* valid from cycle T+1.
  - Result captured on the edge ending cycle T+ALU_WAIT.
  - rsp_valid is high from cycle T+ALU_WAIT+1.
  - Default latency from accept edge to rsp_valid: 2 cycles.
- Illegal op: rsp_valid in cycle T+1.
- Throughput with rsp_ready held high: one op per ALU_WAIT+2 cycles (default 3).
- A requester that drops valid before its ready is not served. No request state is retained across cycles in IDLE.
- rsp_ready sampled outside RESP has no effect.
- The ALU path is treated as combinational from alu_* to alu_result/alu_carry and must settle within ALU_WAIT cycles.

## Test plan
- Single add: req0 a=0xF0, b=0x20, cin=1, sel=00; rsp_ready=1.
  - Required: accepted in cycle 0; rsp_valid in cycle 2 with rsp_id=0, rsp_result=0x0111, rsp_carry per ALU.
  - Then busy=0 in cycle 3.
- Multiply with backpressure: req1 a=0xFF, b=0xFF, sel=10; rsp_ready=0 for 5 cycles, then 1.
  - Required: rsp_result=0xFE01 and rsp_id=1, stable through the stall.
  - Single response handshake; req0_ready/req1_ready stay 0 throughout.
- Round-robin: both requesters valid continuously, 4 ops.
  - Required: grant order 0,1,0,1; each rsp_id matches; each issued op appears exactly once.
- Illegal op: req0 sel=11.
  - Required: rsp_valid the cycle after accept with rsp_err=1, rsp_result=0, rsp_carry=0.
  - alu_sel is unchanged from its prior value.
- Reset mid-op: assert rst_n=0 during WAIT of a sub (a=0x05, b=0x09).
  - Required: immediately all outputs 0 and busy=0; no response after release.
  - The next req0 is accepted normally.
- ALU_WAIT=4: single sub a=0x09, b=0x05.
  - Required: rsp_valid exactly 5 cycles after the accept edge, rsp_result=0x0004.
